muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle sequencer for RV32M ops in the execute stage, beside the ALU.
//  Detects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on the execute instruction and
//  runs an iterative radix-2 shift-add multiply or restoring divide on the operands.
//  Holds the pipeline with stall until the result is ready, then presents it for
//  one cycle for the writeback mux. A flush cancels the operation.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk             in   1     single clock, rising edge
//  rst             in   1     reset: synchronous, active-low
//  instruction_in  in   32    execute-stage instruction (opcode/funct3/funct7 decoded here)
//  in_valid        in   1     instruction_in is a live, non-bubble instruction
//  op_a            in   XLEN  rs1 value (forwarded)
//  op_b            in   XLEN  rs2 value (forwarded)
//  flush           in   1     squash execute stage (branch/jump redirect)
//  stall           out  1     freeze PC and IF/ID/EX pipeline registers
//  result          out  XLEN  M-op result, valid while result_valid=1
//  result_valid    out  1     one-cycle strobe: select result in writeback
// BEHAVIOUR
//  - is_m = opcode 7'b0110011 & funct7 7'b0000001; start = in_valid & is_m & state==IDLE & ~flush.
//  - States: IDLE, BUSY, DONE. IDLE -start-> BUSY (count=XLEN-1); BUSY: one iteration
//    per cycle, count-- ; count==0 -> DONE; DONE -> IDLE unconditionally.
//  - Special cases skip BUSY (IDLE -start-> DONE): divisor==0 (DIV/DIVU q=all ones,
//    REM/REMU r=op_a); DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF (q=0x80000000, r=0).
//  - Latched at start: funct3, |op_a|/|op_b| per signedness, negate-result flag.
//    MULHSU: only op_a signed. Division sign: q neg if signs differ; r takes sign of op_a.
//  - Product register 2*XLEN bits; MUL returns low XLEN, MULH* high XLEN after fixup
//    (two's-complement negate of full 2*XLEN product). Sign fixup in DONE, combinational from latched state.
//  - stall = start | (state==BUSY). DONE cycle: stall=0, result_valid=1, pipeline
//    advances; no new start in DONE (same instruction still on instruction_in).
//  - Latency: normal op stalls XLEN+1 cycles (start + XLEN BUSY), result in cycle XLEN+2.
//    Special case: stall 1 cycle, result next cycle.
//  - Non-M instructions: stall=0, result_valid=0, state stays IDLE.
//  - flush in any state: next state IDLE, result_valid=0 that cycle, no start.
//    flush takes priority over start and over DONE.
//  - Reset (rst=0 at clk edge): state IDLE, count 0, stall 0, result 0,
//    result_valid 0; reset mid-operation discards the operation.
//  - result holds its last value outside DONE; consumers qualify with result_valid.
// TESTING
//  - MUL 7*-3 -> stall high 33 cycles, then result 0xFFFFFFEB, result_valid 1 for 1 cycle.
//  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000;
//    MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  - DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM same -> 0;
//    each with exactly 1 stall cycle.
//  - flush at BUSY cycle 10 -> stall drops next cycle, no result_valid; new MUL 3*4
//    after -> 12.
//  - rst=0 mid-DIV -> stall/result_valid/result 0 next cycle; ADD instruction -> stall never asserted.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M execute-stage unit: radix-2 shift-add multiply and restoring divide,
// stalling the pipeline until a one-cycle result strobe for writeback.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instruction_in,
    input  logic            in_valid,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     count_r;
    logic [2:0]        funct3_r;
    logic              neg_r;
    logic              neg_rem_r;
    logic [XLEN-1:0]   opnd_r;
    logic [2*XLEN-1:0] prod_r;
    logic [XLEN-1:0]   result_r;

    logic [2:0]        funct3_s;
    logic              is_m_s;
    logic              start_s;
    logic              a_signed_s;
    logic              b_signed_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   abs_a_s;
    logic [XLEN-1:0]   abs_b_s;
    logic              div_zero_s;
    logic              div_ovf_s;
    logic [XLEN:0]     add_s;
    logic [XLEN:0]     shl_s;
    logic [XLEN+1:0]   diff_s;
    logic [2*XLEN-1:0] mul_next_s;
    logic [2*XLEN-1:0] div_next_s;
    logic [2*XLEN-1:0] mul_full_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fixed_s;
    logic              unused_fields_s;

    assign funct3_s        = instruction_in[14:12];
    assign is_m_s          = (instruction_in[6:0] == 7'b0110011) && (instruction_in[31:25] == 7'b0000001);
    assign start_s         = in_valid && is_m_s && (state_r == IDLE) && !flush;
    assign unused_fields_s = &{1'b0, instruction_in[24:15], instruction_in[11:7], diff_s[XLEN]};

    // Operand signedness per funct3 and magnitudes for the unsigned datapath
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (funct3_s)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            3'b010: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        a_neg_s    = a_signed_s && op_a[XLEN-1];
        b_neg_s    = b_signed_s && op_b[XLEN-1];
        abs_a_s    = a_neg_s ? (~op_a + {{(XLEN-1){1'b0}}, 1'b1}) : op_a;
        abs_b_s    = b_neg_s ? (~op_b + {{(XLEN-1){1'b0}}, 1'b1}) : op_b;
        div_zero_s = funct3_s[2] && (op_b == {XLEN{1'b0}});
        div_ovf_s  = funct3_s[2] && !funct3_s[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                     && (op_b == {XLEN{1'b1}});
    end

    // One iteration of each algorithm; the divider keeps {remainder, quotient} in prod_r
    always_comb begin
        add_s      = {1'b0, prod_r[2*XLEN-1:XLEN]} + (prod_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        mul_next_s = {add_s, prod_r[XLEN-1:1]};
        shl_s      = {prod_r[2*XLEN-1:XLEN], prod_r[XLEN-1]};
        diff_s     = {1'b0, shl_s} - {2'b00, opnd_r};
        if (diff_s[XLEN+1]) begin
            div_next_s = {shl_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b0};
        end else begin
            div_next_s = {diff_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b1};
        end
    end

    // Sign fixup and result selection from the latched operation
    always_comb begin
        mul_full_s = neg_r ? (~prod_r + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_r;
        quo_s      = neg_r ? (~prod_r[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1}) : prod_r[XLEN-1:0];
        rem_s      = neg_rem_r ? (~prod_r[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1})
                               : prod_r[2*XLEN-1:XLEN];
        case (funct3_r)
            3'b000:                 fixed_s = mul_full_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fixed_s = mul_full_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fixed_s = quo_s;
            default:                fixed_s = rem_s;
        endcase
    end

    assign stall        = start_s || (state_r == BUSY);
    assign result_valid = (state_r == DONE) && !flush;
    assign result       = (state_r == DONE) ? fixed_s : result_r;

    // Sequencer FSM and iterative datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            count_r   <= {CW{1'b0}};
            funct3_r  <= 3'b000;
            neg_r     <= 1'b0;
            neg_rem_r <= 1'b0;
            opnd_r    <= {XLEN{1'b0}};
            prod_r    <= {(2*XLEN){1'b0}};
        end else if (flush) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        funct3_r <= funct3_s;
                        if (div_zero_s) begin
                            // Quotient all ones, remainder is the dividend unchanged
                            state_r   <= DONE;
                            neg_r     <= 1'b0;
                            neg_rem_r <= 1'b0;
                            prod_r    <= {op_a, {XLEN{1'b1}}};
                        end else if (div_ovf_s) begin
                            state_r   <= DONE;
                            neg_r     <= 1'b0;
                            neg_rem_r <= 1'b0;
                            prod_r    <= {{XLEN{1'b0}}, op_a};
                        end else begin
                            state_r   <= BUSY;
                            count_r   <= CW'(XLEN - 1);
                            neg_r     <= a_neg_s ^ b_neg_s;
                            neg_rem_r <= a_neg_s;
                            opnd_r    <= funct3_s[2] ? abs_b_s : abs_a_s;
                            prod_r    <= {{XLEN{1'b0}}, (funct3_s[2] ? abs_a_s : abs_b_s)};
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    prod_r <= funct3_r[2] ? div_next_s : mul_next_s;
                    if (count_r == {CW{1'b0}}) begin
                        state_r <= DONE;
                    end else begin
                        count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Hold the last presented result for consumers outside the strobe cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_r <= {XLEN{1'b0}};
        end else if (state_r == DONE) begin
            result_r <= fixed_s;
        end else begin
            result_r <= result_r;
        end
    end
endmodule
